// File: rtl/axicb_rd_ostd_limiter.sv
// Read-path admission stage: caps outstanding reads, registers AR through a 2-entry
// skid slice, passes R through, and flags stalled completions with a sticky timeout.
module axicb_rd_ostd_limiter #(
  parameter int unsigned AXI_ID_W        = 8,
  parameter int unsigned ARCH_W          = 8,
  parameter int unsigned RCH_W           = 8,
  parameter int unsigned MST_OSTDREQ_NUM = 4,
  parameter int unsigned TIMEOUT_ENABLE  = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  localparam int unsigned CNT_W          = $clog2(MST_OSTDREQ_NUM + 1)
) (
  input  logic              aclk,
  input  logic              srst,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ARCH_W-1:0] s_arch,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              s_rlast,
  output logic [RCH_W-1:0]  s_rch,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ARCH_W-1:0] m_arch,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic              m_rlast,
  input  logic [RCH_W-1:0]  m_rch,
  output logic [CNT_W-1:0]  ostd_cnt,
  output logic              ar_blocked,
  output logic              timeout,
  output logic              err_underflow
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  // IDs travel opaque inside the AR/R payloads.
  if (AXI_ID_W == 0) begin : g_no_id
  end

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [ARCH_W-1:0] main_data_q, main_data_d;
  logic [ARCH_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              timeout_q, timeout_d;
  logic              uf_q, uf_d;

  logic cnt_ok, ar_acc, main_hs, r_hs, r_last_hs;

  assign cnt_ok    = cnt_q < CNT_W'(MST_OSTDREQ_NUM);
  assign s_arready = !skid_valid_q && cnt_ok && !srst;
  assign ar_acc    = s_arvalid && s_arready;
  assign main_hs   = main_valid_q && m_arready;
  assign r_hs      = m_rvalid && s_rready;
  assign r_last_hs = r_hs && m_rlast;

  assign s_rvalid = m_rvalid;
  assign s_rlast  = m_rlast;
  assign s_rch    = m_rch;
  assign m_rready = s_rready;

  assign m_arvalid     = main_valid_q;
  assign m_arch        = main_data_q;
  assign ostd_cnt      = cnt_q;
  assign ar_blocked    = s_arvalid && !cnt_ok;
  assign timeout       = timeout_q;
  assign err_underflow = uf_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (main_hs) begin
      // A full skid blocks acceptance, so skid refill and new beat never collide.
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (ar_acc) begin
        main_data_d = s_arch;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (!main_valid_q) begin
      if (ar_acc) begin
        main_valid_d = 1'b1;
        main_data_d  = s_arch;
      end
    end else if (ar_acc) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_arch;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ar_acc && !r_last_hs) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!ar_acc && r_last_hs && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    uf_d = uf_q || (r_last_hs && cnt_q == '0);
  end

  always_comb begin
    tmr_d = '0;
    if (TIMEOUT_ENABLE != 0 && cnt_q != '0 && !r_hs) begin
      tmr_d = (tmr_q == TMR_W'(TIMEOUT_CYCLES)) ? tmr_q : tmr_q + TMR_W'(1);
    end
    timeout_d = timeout_q || (TIMEOUT_ENABLE != 0 && tmr_d == TMR_W'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
      tmr_q        <= '0;
      timeout_q    <= 1'b0;
      uf_q         <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      timeout_q    <= timeout_d;
      uf_q         <= uf_d;
    end
  end

  // Payload registers need no reset; they are qualified by the valid bits.
  always_ff @(posedge aclk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

endmodule

// File: tb/tb_axicb_rd_ostd_limiter.sv
// Self-checking bench for axicb_rd_ostd_limiter: directed scenarios plus a random run
// checked against a queue-based reference model.
module tb_axicb_rd_ostd_limiter;

  localparam int MAXO = 4;
  localparam int TO   = 16;

  logic       aclk = 1'b0;
  logic       srst;
  logic       s_arvalid, s_arready;
  logic [7:0] s_arch;
  logic       s_rvalid, s_rready, s_rlast;
  logic [7:0] s_rch;
  logic       m_arvalid, m_arready;
  logic [7:0] m_arch;
  logic       m_rvalid, m_rready, m_rlast;
  logic [7:0] m_rch;
  logic [2:0] ostd_cnt;
  logic       ar_blocked, timeout, err_underflow;

  int tests = 0;
  int fails = 0;

  axicb_rd_ostd_limiter #(
    .AXI_ID_W       (8),
    .ARCH_W         (8),
    .RCH_W          (8),
    .MST_OSTDREQ_NUM(MAXO),
    .TIMEOUT_ENABLE (1),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .aclk         (aclk),
    .srst         (srst),
    .s_arvalid    (s_arvalid),
    .s_arready    (s_arready),
    .s_arch       (s_arch),
    .s_rvalid     (s_rvalid),
    .s_rready     (s_rready),
    .s_rlast      (s_rlast),
    .s_rch        (s_rch),
    .m_arvalid    (m_arvalid),
    .m_arready    (m_arready),
    .m_arch       (m_arch),
    .m_rvalid     (m_rvalid),
    .m_rready     (m_rready),
    .m_rlast      (m_rlast),
    .m_rch        (m_rch),
    .ostd_cnt     (ostd_cnt),
    .ar_blocked   (ar_blocked),
    .timeout      (timeout),
    .err_underflow(err_underflow)
  );

  always #5 aclk = ~aclk;

  // Reference model: AR beats in flight as a queue (at most 2 held), count as plain integer.
  logic [7:0] mq[$];
  int         mcnt = 0;
  int         mtmr = 0;
  bit         mto  = 1'b0;
  bit         muf  = 1'b0;

  function automatic bit mdl_arready();
    return !srst && mq.size() < 2 && mcnt < MAXO;
  endfunction

  always @(posedge aclk) begin
    bit acc, rh, rl;
    if (srst) begin
      mq.delete();
      mcnt = 0;
      mtmr = 0;
      mto  = 1'b0;
      muf  = 1'b0;
    end else begin
      acc = s_arvalid && mdl_arready();
      rh  = m_rvalid && s_rready;
      rl  = rh && m_rlast;
      if (mcnt == 0 || rh) mtmr = 0;
      else if (mtmr < TO) mtmr++;
      if (mtmr == TO) mto = 1'b1;
      if (mq.size() > 0 && m_arready) void'(mq.pop_front());
      if (acc) mq.push_back(s_arch);
      if (rl && mcnt == 0) muf = 1'b1;
      if (acc && !rl) mcnt++;
      else if (rl && !acc && mcnt > 0) mcnt--;
    end
  end

  task automatic step();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic idle_inputs();
    s_arvalid = 1'b0;
    s_arch    = '0;
    s_rready  = 1'b1;
    m_arready = 1'b1;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    m_rch     = '0;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    idle_inputs();
    step();
    step();
    tests++;
    if (m_arvalid !== 1'b0 || ostd_cnt !== 3'd0 || timeout !== 1'b0 || err_underflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got arv=%b cnt=%0d to=%b uf=%b expected 0 0 0 0",
               m_arvalid, ostd_cnt, timeout, err_underflow);
    end
    tests++;
    if (s_arready !== 1'b0) begin
      fails++;
      $display("FAIL reset_arready: got %b expected 0", s_arready);
    end
    srst = 1'b0;
    step();
    tests++;
    if (s_arready !== 1'b1) begin
      fails++;
      $display("FAIL release_arready: got %b expected 1", s_arready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    m_arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 8'h10 + 8'(i);
      s_arvalid = 1'b1;
      s_arch    = exp;
      #1;
      tests++;
      if (s_arready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_arready[%0d]: got %b expected 1", i, s_arready);
      end
      step();
      tests++;
      if (m_arvalid !== 1'b1 || m_arch !== exp) begin
        fails++;
        $display("FAIL b2b_order[%0d]: got v=%b %h expected v=1 %h", i, m_arvalid, m_arch, exp);
      end
    end
    s_arch = 8'h14;
    #1;
    tests++;
    if (ostd_cnt !== 3'd4 || s_arready !== 1'b0 || ar_blocked !== 1'b1) begin
      fails++;
      $display("FAIL b2b_limit: got cnt=%0d rdy=%b blk=%b expected 4 0 1",
               ostd_cnt, s_arready, ar_blocked);
    end
    step();
  endtask

  task automatic test_release();
    for (int j = 0; j < 3; j++) begin
      m_rvalid = 1'b1;
      s_rready = 1'b1;
      m_rlast  = (j == 2);
      m_rch    = 8'($urandom);
      #1;
      tests++;
      if (s_rvalid !== 1'b1 || s_rch !== m_rch || s_rlast !== m_rlast || m_rready !== 1'b1) begin
        fails++;
        $display("FAIL r_passthru[%0d]: got v=%b d=%h l=%b rdy=%b expected 1 %h %b 1",
                 j, s_rvalid, s_rch, s_rlast, m_rready, m_rch, m_rlast);
      end
      if (j == 2) begin
        tests++;
        if (s_arready !== 1'b0) begin
          fails++;
          $display("FAIL rlast_same_cycle_arready: got %b expected 0", s_arready);
        end
      end
      step();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    tests++;
    if (ostd_cnt !== 3'd3 || s_arready !== 1'b1) begin
      fails++;
      $display("FAIL release_cnt: got cnt=%0d rdy=%b expected 3 1", ostd_cnt, s_arready);
    end
    step();
    s_arvalid = 1'b0;
    #1;
    tests++;
    if (m_arvalid !== 1'b1 || m_arch !== 8'h14 || ostd_cnt !== 3'd4) begin
      fails++;
      $display("FAIL release_fifth: got v=%b %h cnt=%0d expected 1 14 4", m_arvalid, m_arch, ostd_cnt);
    end
    step();
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    repeat (4) step();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    tests++;
    if (ostd_cnt !== 3'd0) begin
      fails++;
      $display("FAIL drain_cnt: got %0d expected 0", ostd_cnt);
    end
  endtask

  task automatic test_backpressure();
    m_arready = 1'b0;
    s_arvalid = 1'b1;
    s_arch    = 8'hA1;
    step();
    s_arch = 8'hA2;
    #1;
    tests++;
    if (s_arready !== 1'b1) begin
      fails++;
      $display("FAIL bp_skid_accept: got %b expected 1", s_arready);
    end
    step();
    s_arch = 8'hA3;
    #1;
    tests++;
    if (s_arready !== 1'b0 || m_arvalid !== 1'b1 || m_arch !== 8'hA1) begin
      fails++;
      $display("FAIL bp_full: got rdy=%b v=%b %h expected 0 1 a1", s_arready, m_arvalid, m_arch);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      tests++;
      if (m_arch !== 8'hA1) begin
        fails++;
        $display("FAIL bp_stable[%0d]: got %h expected a1", k, m_arch);
      end
    end
    s_arvalid = 1'b0;
    m_arready = 1'b1;
    step();
    tests++;
    if (m_arvalid !== 1'b1 || m_arch !== 8'hA2) begin
      fails++;
      $display("FAIL bp_second: got v=%b %h expected 1 a2", m_arvalid, m_arch);
    end
    step();
    tests++;
    if (m_arvalid !== 1'b0 || ostd_cnt !== 3'd2) begin
      fails++;
      $display("FAIL bp_empty: got v=%b cnt=%0d expected 0 2", m_arvalid, ostd_cnt);
    end
  endtask

  task automatic test_simultaneous();
    s_arvalid = 1'b1;
    s_arch    = 8'h55;
    m_rvalid  = 1'b1;
    m_rlast   = 1'b1;
    s_rready  = 1'b1;
    step();
    s_arvalid = 1'b0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    #1;
    tests++;
    if (ostd_cnt !== 3'd2 || m_arch !== 8'h55) begin
      fails++;
      $display("FAIL simul_cnt: got cnt=%0d %h expected 2 55", ostd_cnt, m_arch);
    end
    step();
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    repeat (2) step();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  task automatic test_underflow_reset();
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    step();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    tests++;
    if (err_underflow !== 1'b1 || ostd_cnt !== 3'd0) begin
      fails++;
      $display("FAIL underflow: got uf=%b cnt=%0d expected 1 0", err_underflow, ostd_cnt);
    end
    m_arready = 1'b0;
    s_arvalid = 1'b1;
    s_arch    = 8'hB1;
    step();
    s_arch = 8'hB2;
    step();
    s_arvalid = 1'b0;
    tests++;
    if (ostd_cnt !== 3'd2 || m_arvalid !== 1'b1) begin
      fails++;
      $display("FAIL buffered: got cnt=%0d v=%b expected 2 1", ostd_cnt, m_arvalid);
    end
    srst = 1'b1;
    step();
    tests++;
    if (m_arvalid !== 1'b0 || ostd_cnt !== 3'd0 || err_underflow !== 1'b0 || s_arready !== 1'b0) begin
      fails++;
      $display("FAIL midburst_reset: got v=%b cnt=%0d uf=%b rdy=%b expected 0 0 0 0",
               m_arvalid, ostd_cnt, err_underflow, s_arready);
    end
    srst = 1'b0;
    step();
    tests++;
    if (s_arready !== 1'b1 || m_arvalid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: got rdy=%b v=%b expected 1 0", s_arready, m_arvalid);
    end
    m_arready = 1'b1;
  endtask

  task automatic test_timeout(input int r_at);
    srst = 1'b1;
    idle_inputs();
    step();
    srst      = 1'b0;
    s_arvalid = 1'b1;
    s_arch    = 8'hC0;
    step();
    s_arvalid = 1'b0;
    if (r_at > 0) begin
      repeat (r_at - 1) step();
      m_rvalid = 1'b1;
      m_rlast  = 1'b0;
      step();
      m_rvalid = 1'b0;
    end
    for (int c = 1; c <= TO + 2; c++) begin
      tests++;
      if (timeout !== (c > TO)) begin
        fails++;
        $display("FAIL timeout_r%0d_c%0d: got %b expected %b", r_at, c, timeout, c > TO);
      end
      if (c <= TO + 1) step();
    end
    srst = 1'b1;
    step();
    srst = 1'b0;
    tests++;
    if (timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clear: got %b expected 0", timeout);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      srst      = ($urandom_range(0, 299) == 0);
      s_arvalid = $urandom_range(0, 2) != 0;
      s_arch    = 8'($urandom);
      m_arready = $urandom_range(0, 3) != 0;
      m_rvalid  = $urandom_range(0, 3) == 0;
      s_rready  = $urandom_range(0, 3) != 0;
      m_rlast   = $urandom_range(0, 1) != 0;
      m_rch     = 8'($urandom);
      #1;
      tests++;
      if (s_arready !== mdl_arready() || ar_blocked !== (s_arvalid && mcnt >= MAXO)) begin
        fails++;
        $display("FAIL rnd_ready[%0d]: got rdy=%b blk=%b expected %b %b", n, s_arready,
                 ar_blocked, mdl_arready(), s_arvalid && mcnt >= MAXO);
      end
      step();
      tests++;
      if (int'(ostd_cnt) != mcnt || ostd_cnt > 3'(MAXO) || m_arvalid !== (mq.size() > 0) ||
          (mq.size() > 0 && m_arch !== mq[0]) || timeout !== mto || err_underflow !== muf) begin
        fails++;
        $display("FAIL rnd_state[%0d]: got cnt=%0d v=%b d=%h to=%b uf=%b expected %0d %b %h %b %b",
                 n, ostd_cnt, m_arvalid, m_arch, timeout, err_underflow, mcnt, mq.size() > 0,
                 (mq.size() > 0) ? mq[0] : 8'h00, mto, muf);
      end
    end
  endtask

  initial begin
    srst = 1'b1;
    idle_inputs();
    @(negedge aclk);
    test_reset();
    test_back_to_back();
    test_release();
    test_backpressure();
    test_simultaneous();
    test_underflow_reset();
    test_timeout(0);
    test_timeout(10);
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
